// File: rtl/imul_resp_accum.sv
// Sums each group of GROUP multiplier products and hands the modular sum plus an
// unsigned-overflow flag downstream through a one-entry output buffer.
module imul_resp_accum #(
   parameter int unsigned NBITS = 32,
   parameter int unsigned GROUP = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_val,
   output logic             in_rdy,
   input  logic [NBITS-1:0] in_msg,
   output logic             out_val,
   input  logic             out_rdy,
   output logic [NBITS-1:0] out_msg,
   output logic             out_ovf
);

   localparam int unsigned   CW   = (GROUP > 1) ? $clog2(GROUP) : 1;
   localparam logic [CW-1:0] LAST = CW'(GROUP - 1);

   logic [CW-1:0]    cnt_q, cnt_d;
   logic [NBITS-1:0] acc_q, acc_d;
   logic             acc_ovf_q, acc_ovf_d;
   logic             out_val_q, out_val_d;
   logic [NBITS-1:0] out_msg_q, out_msg_d;
   logic             out_ovf_q, out_ovf_d;

   logic [NBITS:0]   sum;
   logic             last;
   logic             in_go;
   logic             out_go;

   assign sum    = {1'b0, acc_q} + {1'b0, in_msg};
   assign last   = (cnt_q == LAST);
   // Only the final product needs the buffer, so only it is held off by a full one;
   // in_rdy depends on registered state alone.
   assign in_rdy = !(last && out_val_q);
   assign in_go  = in_val && in_rdy;
   assign out_go = out_val_q && out_rdy;

   always_comb begin
      // NOTE: every next-state signal gets a hold default first so no path infers a latch.
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      acc_ovf_d = acc_ovf_q;
      out_val_d = out_val_q;
      out_msg_d = out_msg_q;
      out_ovf_d = out_ovf_q;

      if (out_go) begin
         out_val_d = 1'b0;
      end

      if (in_go) begin
         if (last) begin
            out_msg_d = sum[NBITS-1:0];
            out_ovf_d = acc_ovf_q | sum[NBITS];
            out_val_d = 1'b1;
            acc_d     = '0;
            acc_ovf_d = 1'b0;
            cnt_d     = '0;
         end else begin
            acc_d     = sum[NBITS-1:0];
            acc_ovf_d = acc_ovf_q | sum[NBITS];
            cnt_d     = cnt_q + CW'(1);
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so all of them update together.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q     <= '0;
         acc_q     <= '0;
         acc_ovf_q <= 1'b0;
         out_val_q <= 1'b0;
         out_msg_q <= '0;
         out_ovf_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         acc_ovf_q <= acc_ovf_d;
         out_val_q <= out_val_d;
         out_msg_q <= out_msg_d;
         out_ovf_q <= out_ovf_d;
      end
   end

   assign out_val = out_val_q;
   assign out_msg = out_msg_q;
   assign out_ovf = out_ovf_q;

endmodule
